// File: rtl/wb_write_arbiter_if.sv
// Write-back arbiter bus: pipeline result, long-latency result and the
// register-file write port, grouped for the wb_write_arbiter block.
interface wb_write_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          pipe_valid;
    logic [4:0]    pipe_reg;
    logic [31:0]   pipe_data;
    logic          pipe_stall;
    logic          lu_valid;
    logic          lu_ready;
    logic [4:0]    lu_reg;
    logic [31:0]   lu_data;
    logic          RegWrite;
    logic [4:0]    WriteReg;
    logic [31:0]   WriteData;
    logic [CW-1:0] fifo_count;

    // Result producers and register-file observer side
    modport master (
        output pipe_valid, pipe_reg, pipe_data, lu_valid, lu_reg, lu_data,
        input  pipe_stall, lu_ready, RegWrite, WriteReg, WriteData, fifo_count
    );

    // Arbiter side
    modport slave (
        input  pipe_valid, pipe_reg, pipe_data, lu_valid, lu_reg, lu_data,
        output pipe_stall, lu_ready, RegWrite, WriteReg, WriteData, fifo_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the in-order pipeline result and a FIFO of
// long-latency results onto the single register-file write port.
// Pipeline has priority; a starvation counter forces the FIFO head through
// after STARVE_MAX consecutive losses, stalling the pipeline that cycle.
// Optional macro WB_BYPASS_EN: an lu result arriving while the FIFO is empty
// and the pipeline is idle goes straight to the output register.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);

    logic [36:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic [SW-1:0] starve_r;
    logic          lu_ready_r;
    logic          regwrite_r;
    logic [4:0]    writereg_r;
    logic [31:0]   writedata_r;

    logic          nonempty_s;
    logic          fifo_win_s;
    logic          pipe_win_s;
    logic          bypass_s;
    logic          push_s;
    logic          grant_s;
    logic [4:0]    grant_reg_s;
    logic [31:0]   grant_data_s;

    // Grant decision, push qualification and next FIFO occupancy
    always_comb begin
        nonempty_s   = (count_r != {CW{1'b0}});
        fifo_win_s   = nonempty_s && (!bus.pipe_valid || (starve_r == STARVE_LIM));
        pipe_win_s   = !fifo_win_s && bus.pipe_valid;
`ifdef WB_BYPASS_EN
        bypass_s     = !nonempty_s && !bus.pipe_valid && bus.lu_valid;
`else
        bypass_s     = 1'b0;
`endif
        push_s       = bus.lu_valid && lu_ready_r && !bypass_s;
        grant_s      = 1'b0;
        grant_reg_s  = 5'd0;
        grant_data_s = 32'd0;
        if (fifo_win_s) begin
            grant_s      = 1'b1;
            grant_reg_s  = mem_r[rd_ptr_r][36:32];
            grant_data_s = mem_r[rd_ptr_r][31:0];
        end else if (pipe_win_s) begin
            grant_s      = 1'b1;
            grant_reg_s  = bus.pipe_reg;
            grant_data_s = bus.pipe_data;
        end else if (bypass_s) begin
            grant_s      = 1'b1;
            grant_reg_s  = bus.lu_reg;
            grant_data_s = bus.lu_data;
        end else begin
            grant_s      = 1'b0;
        end
        case ({push_s, fifo_win_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers gate them
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bus.lu_reg, bus.lu_data};
        end
    end

    // Pointers, occupancy, starvation counter and write-port registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            starve_r    <= {SW{1'b0}};
            lu_ready_r  <= 1'b1;
            regwrite_r  <= 1'b0;
            writereg_r  <= 5'd0;
            writedata_r <= 32'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (fifo_win_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            lu_ready_r <= (count_next_s < DEPTH_C);
            if (!nonempty_s || fifo_win_s) begin
                starve_r <= {SW{1'b0}};
            end else if (pipe_win_s && (starve_r != STARVE_LIM)) begin
                starve_r <= starve_r + SW'(1);
            end
            if (grant_s) begin
                regwrite_r  <= (grant_reg_s != 5'd0);
                writereg_r  <= grant_reg_s;
                writedata_r <= grant_data_s;
            end else begin
                regwrite_r  <= 1'b0;
            end
        end
    end

    assign bus.pipe_stall = bus.pipe_valid && fifo_win_s;
    assign bus.lu_ready   = lu_ready_r;
    assign bus.RegWrite   = regwrite_r;
    assign bus.WriteReg   = writereg_r;
    assign bus.WriteData  = writedata_r;
    assign bus.fifo_count = count_r;
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-back stage directly upstream of the 32x32 register file.
- Merges two result sources onto the file's single write port (RegWrite/WriteReg/WriteData):
  - the in-order pipeline result;
  - a long-latency unit result (load/mul/div), buffered in a small FIFO.
- Pipeline has priority. A starvation counter guarantees FIFO progress, and the pipeline is stalled when the FIFO wins a cycle.

Parameters:
- DEPTH, 4: FIFO entries for long-latency results; power of 2, min 2.
- STARVE_MAX, 3: consecutive cycles the FIFO head may lose before it is forced through.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pipe_valid  in  1  pipeline result valid this cycle.
- pipe_reg  in  5  destination register of pipeline result.
- pipe_data  in  32  pipeline result data.
- pipe_stall  out  1  combinational; 1 = pipeline result not taken this cycle, hold inputs.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  registered; 1 = FIFO can accept (count < DEPTH).
- lu_reg  in  5  destination register of long-latency result.
- lu_data  in  32  long-latency result data.
- RegWrite  out  1  registered write enable to register file.
- WriteReg  out  5  registered write address.
- WriteData  out  32  registered write data.
- fifo_count  out  $clog2(DEPTH)+1  registered FIFO occupancy.

Behaviour:
- Reset (rst=0, async): RegWrite=0, WriteReg=0, WriteData=0, fifo_count=0, lu_ready=1, starvation counter=0, FIFO pointers=0. FIFO contents are don't-care.
- Push: lu_valid && lu_ready stores {lu_reg, lu_data} at the tail. An entry is eligible for selection from the next cycle (2-cycle minimum lu-to-RegWrite latency).
- Grant, evaluated each cycle:
  - FIFO wins if the FIFO is non-empty and (!pipe_valid or starve == STARVE_MAX).
  - Otherwise the pipeline wins if pipe_valid.
  - Otherwise there is no grant.
- pipe_stall = pipe_valid && FIFO wins.
- Output register, loaded on the next edge:
  - RegWrite = granted && (granted reg != 0). Writes to $0 are consumed but suppressed.
  - WriteReg/WriteData load the granted entry.
  - With no grant, RegWrite=0 and WriteReg/WriteData hold their previous values.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when the FIFO is non-empty and the pipeline wins.
  - Clears to 0 on a FIFO pop or when the FIFO is empty.
- Simultaneous push and pop: allowed; count unchanged; pointers wrap mod DEPTH.
- Full: lu_ready=0 for the whole cycle, even if a pop occurs in that cycle, so no push can occur when full. lu_ready is recomputed from the next count.
- Empty: no pop; pop pointer is unchanged.
- Ordering: FIFO entries drain strictly in arrival order. Same-register writes from both sources are applied in grant order (last granted wins). Hazard avoidance beyond that belongs to the issue logic.
- Reset mid-operation: all queued entries are discarded; no RegWrite pulse is issued after reset release until a new grant.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, pipe_valid=0 and lu_valid=1, the lu result goes straight to the output register. It is not pushed, giving RegWrite on the next edge (1-cycle latency). lu_ready behaviour is unchanged.
- Undefined: every lu result passes through the FIFO (2-cycle minimum latency).

Test Plan:
- Reset: hold rst=0 while driving inputs -> RegWrite=0, WriteReg=0, WriteData=0, fifo_count=0, lu_ready=1 throughout; no write after release with inputs idle.
- Pipeline only: pipe_valid=1, reg 5, data 0xDEADBEEF -> next edge RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF, pipe_stall=0. Same with reg 0 -> RegWrite=0.
- LU only (macro off): lu push reg 7, data 0x12345678 at cycle 0 -> RegWrite=1, WriteReg=7 after edge 2. With WB_BYPASS_EN -> after edge 1.
- Starvation: 1 FIFO entry (reg 9) plus continuous pipe_valid -> pipeline wins 3 cycles, then cycle 4 pipe_stall=1 and WriteReg=9. Counter clears, pipeline resumes.
- Full/wrap: 4 pushes with pipe busy -> fifo_count=4, lu_ready=0, extra lu_valid ignored. Then drain 4 plus push 4 more -> outputs in exact push order across pointer wrap.
- Async reset mid-drain: rst=0 with fifo_count=3 -> immediate RegWrite=0, fifo_count=0. After release no stale entry is written.
